// File: rtl/sprite_pkg.sv
// Shared types and helpers for the multi-sprite bracket unit.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } offset_t;

    // Map an unrotated in-sprite offset to bitmap coordinates; side_m1 is OBJ_SIZE-1.
    function automatic offset_t rotate_offset(dir_t dir, coord_t rel_x, coord_t rel_y,
                                              coord_t side_m1);
        offset_t o;
        unique case (dir)
            DIR_UP:    begin o.x = side_m1 - rel_y; o.y = rel_x;           end
            DIR_RIGHT: begin o.x = rel_x;           o.y = rel_y;           end
            DIR_DOWN:  begin o.x = rel_y;           o.y = side_m1 - rel_x; end
            default:   begin o.x = side_m1 - rel_x; o.y = side_m1 - rel_y; end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sprite_hit_stage.sv
// Per-sprite frame shadow registers and the first pipeline stage (hit test + relative offset).
module sprite_hit_stage
    import sprite_pkg::*;
#(
    parameter int unsigned OBJ_SIZE = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame_i,
    input  coord_t     pixel_x_i,
    input  coord_t     pixel_y_i,
    input  coord_t     top_left_x_i,
    input  coord_t     top_left_y_i,
    input  logic [1:0] dir_i,
    input  logic       enable_i,
    output logic       hit_o,
    output coord_t     rel_x_o,
    output coord_t     rel_y_o,
    output dir_t       dir_o
);

    localparam logic [11:0] SizeExt = 12'(OBJ_SIZE);

    coord_t sh_x_q, sh_y_q;
    dir_t   sh_dir_q;
    logic   sh_en_q;

    logic   hit_q;
    coord_t rel_x_q, rel_y_q;
    dir_t   dir_q;

    logic [11:0] x_end, y_end;
    logic        hit_d;

    // Shadow registers: live inputs only take effect at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x_q   <= '0;
            sh_y_q   <= '0;
            sh_dir_q <= DIR_UP;
            sh_en_q  <= 1'b0;
        end else if (start_of_frame_i) begin
            sh_x_q   <= top_left_x_i;
            sh_y_q   <= top_left_y_i;
            sh_dir_q <= dir_t'(dir_i);
            sh_en_q  <= enable_i;
        end
    end

    // Rectangle test; upper bounds are 12 bits so sprites near 2047 do not wrap.
    always_comb begin
        x_end = {1'b0, sh_x_q} + SizeExt;
        y_end = {1'b0, sh_y_q} + SizeExt;
        hit_d = sh_en_q
              && (pixel_x_i >= sh_x_q) && ({1'b0, pixel_x_i} < x_end)
              && (pixel_y_i >= sh_y_q) && ({1'b0, pixel_y_i} < y_end);
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q   <= 1'b0;
            rel_x_q <= '0;
            rel_y_q <= '0;
            dir_q   <= DIR_UP;
        end else begin
            hit_q   <= hit_d;
            rel_x_q <= pixel_x_i - sh_x_q;
            rel_y_q <= pixel_y_i - sh_y_q;
            dir_q   <= sh_dir_q;
        end
    end

    assign hit_o   = hit_q;
    assign rel_x_o = rel_x_q;
    assign rel_y_o = rel_y_q;
    assign dir_o   = dir_q;

endmodule

// File: rtl/multi_sprite_bracket.sv
// N-sprite bracket: parallel hit stages, then priority select, rotation and collision tracking.
module multi_sprite_bracket
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_OBJ   = 4,
    parameter int unsigned OBJ_SIZE  = 32,
    parameter logic [7:0]  OBJ_COLOR = 8'h5b
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        startOfFrame,
    input  logic [10:0]                                 pixelX,
    input  logic [10:0]                                 pixelY,
    input  logic [NUM_OBJ-1:0][10:0]                    topLeftX,
    input  logic [NUM_OBJ-1:0][10:0]                    topLeftY,
    input  logic [NUM_OBJ-1:0][1:0]                     objDir,
    input  logic [NUM_OBJ-1:0]                          objEnable,
    output logic                                        drawingRequest,
    output logic [$clog2(NUM_OBJ > 1 ? NUM_OBJ : 2)-1:0] objIndex,
    output logic [10:0]                                 offsetX,
    output logic [10:0]                                 offsetY,
    output logic [7:0]                                  RGBout,
    output logic                                        collision,
    output logic [NUM_OBJ-1:0]                          collisionSticky
);

    localparam int unsigned IdxW   = $clog2(NUM_OBJ > 1 ? NUM_OBJ : 2);
    localparam coord_t      SideM1 = coord_t'(OBJ_SIZE - 1);

    logic [NUM_OBJ-1:0] s1_hit;
    coord_t             s1_rel_x [NUM_OBJ];
    coord_t             s1_rel_y [NUM_OBJ];
    dir_t               s1_dir   [NUM_OBJ];

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_stage
        sprite_hit_stage #(
            .OBJ_SIZE (OBJ_SIZE)
        ) u_stage (
            .clk              (clk),
            .reset            (reset),
            .start_of_frame_i (startOfFrame),
            .pixel_x_i        (pixelX),
            .pixel_y_i        (pixelY),
            .top_left_x_i     (topLeftX[g]),
            .top_left_y_i     (topLeftY[g]),
            .dir_i            (objDir[g]),
            .enable_i         (objEnable[g]),
            .hit_o            (s1_hit[g]),
            .rel_x_o          (s1_rel_x[g]),
            .rel_y_o          (s1_rel_y[g]),
            .dir_o            (s1_dir[g])
        );
    end

    logic               win_found;
    logic [IdxW-1:0]    win_idx;
    offset_t            win_off;
    int unsigned        hit_cnt;

    logic               dr_d, dr_q;
    logic [IdxW-1:0]    idx_d, idx_q;
    coord_t             offx_d, offx_q, offy_d, offy_q;
    logic [7:0]         rgb_d, rgb_q;
    logic               coll_d, coll_q;
    logic [NUM_OBJ-1:0] sticky_d, sticky_q;

    // Stage 2 combinational: lowest-index priority, rotation, popcount, sticky update.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_off   = '0;
        hit_cnt   = 0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (s1_hit[i]) begin
                hit_cnt = hit_cnt + 1;
                if (!win_found) begin
                    win_found = 1'b1;
                    win_idx   = IdxW'(i);
                    win_off   = rotate_offset(s1_dir[i], s1_rel_x[i], s1_rel_y[i], SideM1);
                end
            end
        end

        dr_d   = win_found;
        idx_d  = win_idx;
        offx_d = win_off.x;
        offy_d = win_off.y;
        rgb_d  = win_found ? OBJ_COLOR : TRANSPARENT_ENCODING;

        // Frame start clears sticky state and drops any collision from the old frame.
        coll_d   = (hit_cnt >= 2) && !startOfFrame;
        sticky_d = sticky_q;
        if (startOfFrame) begin
            sticky_d = '0;
        end else if (hit_cnt >= 2) begin
            sticky_d = sticky_q | s1_hit;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr_q     <= 1'b0;
            idx_q    <= '0;
            offx_q   <= '0;
            offy_q   <= '0;
            rgb_q    <= TRANSPARENT_ENCODING;
            coll_q   <= 1'b0;
            sticky_q <= '0;
        end else begin
            dr_q     <= dr_d;
            idx_q    <= idx_d;
            offx_q   <= offx_d;
            offy_q   <= offy_d;
            rgb_q    <= rgb_d;
            coll_q   <= coll_d;
            sticky_q <= sticky_d;
        end
    end

    assign drawingRequest  = dr_q;
    assign objIndex        = idx_q;
    assign offsetX         = offx_q;
    assign offsetY         = offy_q;
    assign RGBout          = rgb_q;
    assign collision       = coll_q;
    assign collisionSticky = sticky_q;

endmodule

// File: tb/tb_multi_sprite_bracket.sv
// Directed bench for multi_sprite_bracket (NUM_OBJ=4, OBJ_SIZE=32).
module tb_multi_sprite_bracket;

    logic             clk = 1'b0;
    logic             reset;
    logic             startOfFrame;
    logic [10:0]      pixelX, pixelY;
    logic [3:0][10:0] topLeftX, topLeftY;
    logic [3:0][1:0]  objDir;
    logic [3:0]       objEnable;
    logic             drawingRequest;
    logic [1:0]       objIndex;
    logic [10:0]      offsetX, offsetY;
    logic [7:0]       RGBout;
    logic             collision;
    logic [3:0]       collisionSticky;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_sprite_bracket #(
        .NUM_OBJ   (4),
        .OBJ_SIZE  (32),
        .OBJ_COLOR (8'h5b)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .objDir          (objDir),
        .objEnable       (objEnable),
        .drawingRequest  (drawingRequest),
        .objIndex        (objIndex),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .RGBout          (RGBout),
        .collision       (collision),
        .collisionSticky (collisionSticky)
    );

    typedef struct {
        string       name;
        logic [10:0] sx, sy;
        logic [1:0]  sdir;
        logic [10:0] px, py;
        logic        exp_dr;
        logic [10:0] exp_ox, exp_oy;
    } vec_t;

    vec_t vecs [10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare the pixel-path outputs as one packed word.
    task automatic chk_pix(input string name, input logic dr, input logic [1:0] idx,
                           input logic [10:0] ox, input logic [10:0] oy);
        logic [7:0] rgb;
        rgb = dr ? 8'h5b : 8'hFF;
        chk(name, 64'({drawingRequest, objIndex, offsetX, offsetY, RGBout}),
            64'({dr, idx, ox, oy, rgb}));
    endtask

    task automatic frame_pulse();
        startOfFrame = 1'b1;
        step(1);
        startOfFrame = 1'b0;
    endtask

    task automatic set_pixel(input logic [10:0] x, input logic [10:0] y);
        pixelX = x;
        pixelY = y;
        step(2);
    endtask

    task automatic only_sprite(input int i, input logic [10:0] x, input logic [10:0] y,
                               input logic [1:0] d);
        objEnable   = '0;
        topLeftX[i] = x;
        topLeftY[i] = y;
        objDir[i]   = d;
        objEnable[i] = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"basic_hit",   11'd100,  11'd50,   2'b01, 11'd100,  11'd50,   1'b1, 11'd0,  11'd0};
        vecs[1] = '{"right_edge",  11'd100,  11'd50,   2'b01, 11'd132,  11'd50,   1'b0, 11'd0,  11'd0};
        vecs[2] = '{"far_corner",  11'd100,  11'd50,   2'b01, 11'd131,  11'd81,   1'b1, 11'd31, 11'd31};
        vecs[3] = '{"left_miss",   11'd100,  11'd50,   2'b01, 11'd99,   11'd50,   1'b0, 11'd0,  11'd0};
        vecs[4] = '{"rot_up",      11'd0,    11'd0,    2'b00, 11'd5,    11'd3,    1'b1, 11'd28, 11'd5};
        vecs[5] = '{"rot_down",    11'd0,    11'd0,    2'b10, 11'd5,    11'd3,    1'b1, 11'd3,  11'd26};
        vecs[6] = '{"rot_left",    11'd0,    11'd0,    2'b11, 11'd5,    11'd3,    1'b1, 11'd26, 11'd28};
        vecs[7] = '{"rot_right",   11'd0,    11'd0,    2'b01, 11'd5,    11'd3,    1'b1, 11'd5,  11'd3};
        vecs[8] = '{"no_wrap",     11'd2030, 11'd2030, 2'b01, 11'd5,    11'd5,    1'b0, 11'd0,  11'd0};
        vecs[9] = '{"edge_hit",    11'd2030, 11'd2030, 2'b01, 11'd2040, 11'd2040, 1'b1, 11'd10, 11'd10};

        reset        = 1'b1;
        startOfFrame = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        topLeftX     = '0;
        topLeftY     = '0;
        objDir       = '0;
        objEnable    = '0;
        step(2);
        chk_pix("reset_pix", 1'b0, 2'd0, 11'd0, 11'd0);
        chk("reset_coll", 64'({collision, collisionSticky}), 64'(5'b0));
        reset = 1'b0;
        step(1);

        // Table-driven single-sprite vectors.
        for (int v = 0; v < 10; v++) begin
            only_sprite(0, vecs[v].sx, vecs[v].sy, vecs[v].sdir);
            frame_pulse();
            set_pixel(vecs[v].px, vecs[v].py);
            chk_pix(vecs[v].name, vecs[v].exp_dr, 2'd0, vecs[v].exp_ox, vecs[v].exp_oy);
            chk({vecs[v].name, "_coll"}, 64'(collision), 64'(0));
        end

        // Two overlapping sprites: priority, collision, sticky, then clear on frame start.
        objEnable   = '0;
        topLeftX[1] = 11'd30; topLeftY[1] = 11'd30; objDir[1] = 2'b01;
        topLeftX[2] = 11'd35; topLeftY[2] = 11'd35; objDir[2] = 2'b01;
        objEnable   = 4'b0110;
        frame_pulse();
        set_pixel(11'd40, 11'd40);
        chk_pix("coll_pix", 1'b1, 2'd1, 11'd10, 11'd10);
        chk("coll_flag", 64'(collision), 64'(1));
        chk("coll_sticky", 64'(collisionSticky), 64'(4'b0110));
        frame_pulse();
        chk("sof_clear_sticky", 64'(collisionSticky), 64'(4'b0000));
        chk("sof_drop_coll", 64'(collision), 64'(0));
        // Sprite 2 alone after moving away from sprite 1: single hit, no collision.
        set_pixel(11'd66, 11'd66);
        chk_pix("sprite2_only", 1'b1, 2'd2, 11'd31, 11'd31);
        chk("sprite2_nocoll", 64'(collision), 64'(0));

        // Live position change mid-frame is ignored until the next frame start.
        only_sprite(0, 11'd100, 11'd50, 2'b01);
        frame_pulse();
        topLeftX[0] = 11'd200;
        set_pixel(11'd100, 11'd50);
        chk_pix("shadow_old_hit", 1'b1, 2'd0, 11'd0, 11'd0);
        set_pixel(11'd200, 11'd50);
        chk_pix("shadow_new_miss", 1'b0, 2'd0, 11'd0, 11'd0);
        frame_pulse();
        set_pixel(11'd200, 11'd50);
        chk_pix("shadow_new_hit", 1'b1, 2'd0, 11'd0, 11'd0);
        set_pixel(11'd100, 11'd50);
        chk_pix("shadow_old_miss", 1'b0, 2'd0, 11'd0, 11'd0);

        // Asynchronous reset mid-frame, then no drawing until the next frame start.
        set_pixel(11'd205, 11'd52);
        chk_pix("pre_reset_hit", 1'b1, 2'd0, 11'd5, 11'd2);
        reset = 1'b1;
        #1;
        chk_pix("async_reset_pix", 1'b0, 2'd0, 11'd0, 11'd0);
        step(1);
        reset = 1'b0;
        step(3);
        chk_pix("post_reset_nodraw", 1'b0, 2'd0, 11'd0, 11'd0);
        frame_pulse();
        step(2);
        chk_pix("post_reset_sof_hit", 1'b1, 2'd0, 11'd5, 11'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
